// File: rtl/mprj_io_pad_bist_pkg.sv
// Shared constants for the user-project pad BIST: drive modes, FSM state
// encodings, phase enum and the fixed pattern count.
package mprj_io_pad_bist_pkg;

    localparam logic [2:0] DM_OUT = 3'b110;
    localparam logic [2:0] DM_IN  = 3'b001;

    localparam int NFIXED = 4;

    typedef logic [2:0] state_t;
    localparam state_t ST_IDLE   = 3'd0;
    localparam state_t ST_SETUP  = 3'd1;
    localparam state_t ST_DRIVE  = 3'd2;
    localparam state_t ST_SETTLE = 3'd3;
    localparam state_t ST_SAMPLE = 3'd4;
    localparam state_t ST_DONE   = 3'd5;

    typedef enum logic [1:0] {
        PH_SELF = 2'd0,
        PH_EVEN = 2'd1,
        PH_ODD  = 2'd2
    } phase_e;

endpackage

// File: rtl/mprj_io_pad_bist_patgen.sv
// Combinational test-pattern decoder: four fixed patterns followed by an
// optional walking-one sequence, selected by pattern index.
module mprj_io_pad_bist_patgen
    import mprj_io_pad_bist_pkg::*;
#(
    parameter int NPADS = 38,
    parameter int IW    = 8
) (
    input  logic [IW-1:0]    pat_idx,
    output logic [NPADS-1:0] pattern
);

    always_comb begin
        pattern = '0;
        for (int i = 0; i < NPADS; i++) begin
            if (pat_idx == IW'(1))
                pattern[i] = 1'b1;
            else if (pat_idx == IW'(2))
                pattern[i] = ((i % 2) == 1);
            else if (pat_idx == IW'(3))
                pattern[i] = ((i % 2) == 0);
            else if (int'(pat_idx) == NFIXED + i)
                pattern[i] = 1'b1;
        end
    end

endmodule

// File: rtl/mprj_io_pad_bist.sv
// Pad BIST sequencer between the GPIO control block and chip_io: passes core
// controls through when idle, otherwise drives patterns and records mismatches.
module mprj_io_pad_bist
    import mprj_io_pad_bist_pkg::*;
#(
    parameter int NPADS  = 38,
    parameter int SETTLE = 4,
    parameter int WALK   = 1,
    parameter int PAIRS  = 0
) (
    input  logic                 clk,
    input  logic                 RSTB,
    input  logic                 start,
    input  logic                 abort,
    input  logic [NPADS-1:0]     core_out,
    input  logic [NPADS-1:0]     core_oeb,
    input  logic [NPADS-1:0]     core_inp_dis,
    input  logic [3*NPADS-1:0]   core_dm,
    input  logic [NPADS-1:0]     io_in,
    output logic [NPADS-1:0]     io_out,
    output logic [NPADS-1:0]     io_oeb,
    output logic [NPADS-1:0]     io_inp_dis,
    output logic [3*NPADS-1:0]   io_dm,
    output logic                 busy,
    output logic                 done,
    output logic                 pass,
    output logic [NPADS-1:0]     fail_mask
);

    localparam int     P          = NFIXED + WALK * NPADS;
    localparam int     PW         = $clog2(P + 1);
    localparam phase_e LAST_PHASE = (PAIRS != 0) ? PH_ODD : PH_SELF;

    state_t             state;
    phase_e             phase;
    logic [PW-1:0]      pat_idx;
    logic [7:0]         settle_cnt;
    logic [NPADS-1:0]   pattern;
    logic [NPADS-1:0]   mismatch;
    logic [NPADS-1:0]   bist_out;
    logic [NPADS-1:0]   bist_oeb;
    logic [NPADS-1:0]   bist_inp_dis;
    logic [3*NPADS-1:0] bist_dm;

    mprj_io_pad_bist_patgen #(
        .NPADS (NPADS),
        .IW    (PW)
    ) u_patgen (
        .pat_idx (pat_idx),
        .pattern (pattern)
    );

    assign busy = (state != ST_IDLE) && (state != ST_DONE);

    // In pair phases the receiving half becomes inputs; an unpaired last pad is parked as an input.
    always_comb begin
        bist_out     = (state == ST_SETUP) ? '0 : pattern;
        bist_oeb     = '0;
        bist_inp_dis = '0;
        bist_dm      = {NPADS{DM_OUT}};
        if (phase != PH_SELF) begin
            for (int i = 0; i < NPADS; i++) begin
                if ((((i % 2) == 1) == (phase == PH_EVEN)) || (i >= 2 * (NPADS / 2))) begin
                    bist_oeb[i]        = 1'b1;
                    bist_dm[3*i +: 3]  = DM_IN;
                end
            end
        end
    end

    always_comb begin
        mismatch = '0;
        case (phase)
            PH_SELF: mismatch = io_in ^ pattern;
            PH_EVEN:
                for (int k = 0; k < NPADS / 2; k++)
                    mismatch[2*k+1] = io_in[2*k+1] ^ pattern[2*k];
            PH_ODD:
                for (int k = 0; k < NPADS / 2; k++)
                    mismatch[2*k] = io_in[2*k] ^ pattern[2*k+1];
            default: mismatch = '0;
        endcase
    end

    assign io_out     = busy ? bist_out     : core_out;
    assign io_oeb     = busy ? bist_oeb     : core_oeb;
    assign io_inp_dis = busy ? bist_inp_dis : core_inp_dis;
    assign io_dm      = busy ? bist_dm      : core_dm;

    always_ff @(posedge clk) begin
        if (RSTB) begin
            state      <= ST_IDLE;
            phase      <= PH_SELF;
            pat_idx    <= '0;
            settle_cnt <= '0;
            done       <= 1'b0;
            pass       <= 1'b0;
            fail_mask  <= '0;
        end else if (busy && abort) begin
            state      <= ST_IDLE;
            phase      <= PH_SELF;
            pat_idx    <= '0;
            settle_cnt <= '0;
        end else begin
            case (state)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        state     <= ST_SETUP;
                        phase     <= PH_SELF;
                        pat_idx   <= '0;
                        fail_mask <= '0;
                        done      <= 1'b0;
                        pass      <= 1'b0;
                    end
                end
                ST_SETUP: state <= ST_DRIVE;
                ST_DRIVE: begin
                    settle_cnt <= '0;
                    state      <= ST_SETTLE;
                end
                ST_SETTLE: begin
                    if (settle_cnt == 8'(SETTLE - 1))
                        state <= ST_SAMPLE;
                    else
                        settle_cnt <= settle_cnt + 8'd1;
                end
                ST_SAMPLE: begin
                    fail_mask <= fail_mask | mismatch;
                    if (pat_idx == PW'(P - 1)) begin
                        pat_idx <= '0;
                        if (phase == LAST_PHASE) begin
                            state <= ST_DONE;
                            done  <= 1'b1;
                            pass  <= ~|(fail_mask | mismatch);
                        end else begin
                            state <= ST_SETUP;
                            phase <= (phase == PH_SELF) ? PH_EVEN : PH_ODD;
                        end
                    end else begin
                        pat_idx <= pat_idx + 1'b1;
                        state   <= ST_DRIVE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mprj_io_pad_bist.sv
// Bench for mprj_io_pad_bist: three instances (plain, walking-one, pair
// loopback) with behavioural pad models and injectable board faults.
module tb_mprj_io_pad_bist;

    localparam int NP    = 38;
    localparam int LIMIT = 400;

    logic clk = 1'b0;
    logic RSTB, start, abort;
    logic [NP-1:0]   core_out, core_oeb, core_inp_dis;
    logic [3*NP-1:0] core_dm;

    logic [NP-1:0]   o0, oe0, id0, in0, mask0;
    logic [NP-1:0]   o1, oe1, id1, in1, mask1;
    logic [NP-1:0]   o2, oe2, id2, in2, mask2;
    logic [3*NP-1:0] dm0, dm1, dm2;
    logic busy0, busy1, busy2, done0, done1, done2, pass0, pass1, pass2;
    logic [2:0]      busy_v, done_v, pass_v;
    logic [NP-1:0]   mask_a [3];

    bit stuck5, short1213, open67;

    typedef struct {
        int          dut;
        int          lat;
        logic [NP-1:0] mask;
        logic        pass;
    } exp_t;
    exp_t sb[$];

    int            vectors = 0;
    int            miscompares = 0;
    bit [2:0]      got_seen;
    int            got_lat [3];
    logic [NP-1:0] got_mask [3];
    logic          got_pass [3];
    logic          got_busy [3];
    logic            s_busy, s_done;
    logic [NP-1:0]   s_out, s_oeb, s_mask;
    logic [3*NP-1:0] s_dm;

    always #5 clk = ~clk;

    mprj_io_pad_bist #(.NPADS(NP), .SETTLE(4), .WALK(0), .PAIRS(0)) dut0 (
        .clk(clk), .RSTB(RSTB), .start(start), .abort(abort),
        .core_out(core_out), .core_oeb(core_oeb), .core_inp_dis(core_inp_dis), .core_dm(core_dm),
        .io_in(in0), .io_out(o0), .io_oeb(oe0), .io_inp_dis(id0), .io_dm(dm0),
        .busy(busy0), .done(done0), .pass(pass0), .fail_mask(mask0));

    mprj_io_pad_bist #(.NPADS(NP), .SETTLE(4), .WALK(1), .PAIRS(0)) dut1 (
        .clk(clk), .RSTB(RSTB), .start(start), .abort(abort),
        .core_out(core_out), .core_oeb(core_oeb), .core_inp_dis(core_inp_dis), .core_dm(core_dm),
        .io_in(in1), .io_out(o1), .io_oeb(oe1), .io_inp_dis(id1), .io_dm(dm1),
        .busy(busy1), .done(done1), .pass(pass1), .fail_mask(mask1));

    mprj_io_pad_bist #(.NPADS(NP), .SETTLE(4), .WALK(0), .PAIRS(1)) dut2 (
        .clk(clk), .RSTB(RSTB), .start(start), .abort(abort),
        .core_out(core_out), .core_oeb(core_oeb), .core_inp_dis(core_inp_dis), .core_dm(core_dm),
        .io_in(in2), .io_out(o2), .io_oeb(oe2), .io_inp_dis(id2), .io_dm(dm2),
        .busy(busy2), .done(done2), .pass(pass2), .fail_mask(mask2));

    assign busy_v = {busy2, busy1, busy0};
    assign done_v = {done2, done1, done0};
    assign pass_v = {pass2, pass1, pass0};

    always_comb begin
        mask_a[0] = mask0;
        mask_a[1] = mask1;
        mask_a[2] = mask2;
    end

    // Pad models: driven pads read back their own output; pad 5 may be stuck low.
    always_comb begin
        for (int i = 0; i < NP; i++) in0[i] = oe0[i] ? 1'b0 : o0[i];
        if (stuck5) in0[5] = 1'b0;
    end

    always_comb begin
        for (int i = 0; i < NP; i++) in1[i] = oe1[i] ? 1'b0 : o1[i];
        if (short1213) begin
            in1[12] = o1[12] | o1[13];
            in1[13] = o1[12] | o1[13];
        end
    end

    // Board strap between pad 2k and 2k+1; an open strap leaves the input at 0.
    always_comb begin
        for (int i = 0; i < NP; i++) begin
            if (!oe2[i])
                in2[i] = o2[i];
            else if (!oe2[i ^ 1] && !(open67 && (i == 6 || i == 7)))
                in2[i] = o2[i ^ 1];
            else
                in2[i] = 1'b0;
        end
    end

    task automatic run_and_wait(input int restart_at);
        got_seen = 3'b000;
        for (int d = 0; d < 3; d++) got_lat[d] = 0;
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        s_busy = busy0; s_done = done0; s_out = o0; s_oeb = oe0; s_dm = dm0; s_mask = mask0;
        for (int cyc = 1; cyc <= LIMIT; cyc++) begin
            start = (cyc == restart_at);
            @(negedge clk);
            for (int d = 0; d < 3; d++) begin
                if (!got_seen[d] && done_v[d]) begin
                    got_seen[d] = 1'b1;
                    got_lat[d]  = cyc;
                    got_mask[d] = mask_a[d];
                    got_pass[d] = pass_v[d];
                    got_busy[d] = busy_v[d];
                end
            end
            if (got_seen == 3'b111) break;
        end
        start = 1'b0;
    endtask

    task automatic test_reset();
        RSTB = 1'b1; start = 1'b0; abort = 1'b0;
        stuck5 = 1'b0; short1213 = 1'b0; open67 = 1'b0;
        core_out = 38'h0F0F0; core_oeb = '0; core_inp_dis = '0; core_dm = {NP{3'b110}};
        repeat (3) @(posedge clk);
        @(negedge clk);
        vectors++;
        if ({busy_v, done_v, pass_v} !== 9'b0) begin
            miscompares++;
            $display("[TB] FAIL reset_flags: got %b want %b", {busy_v, done_v, pass_v}, 9'b0);
        end
        vectors++;
        if ({mask0, mask1, mask2} !== '0) begin
            miscompares++;
            $display("[TB] FAIL reset_mask: got %h want 0", {mask0, mask1, mask2});
        end
        vectors++;
        if (o0 !== core_out || dm0 !== core_dm) begin
            miscompares++;
            $display("[TB] FAIL reset_pads: got out %h dm %h want out %h dm %h", o0, dm0, core_out, core_dm);
        end
        RSTB = 1'b0;
    endtask

    task automatic test_passthrough(input logic want_done);
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            if (c > 0) begin
                core_out     = NP'({$urandom(), $urandom()});
                core_oeb     = NP'({$urandom(), $urandom()});
                core_inp_dis = NP'({$urandom(), $urandom()});
                core_dm      = (3*NP)'({$urandom(), $urandom(), $urandom(), $urandom()});
            end
            #1;
            vectors++;
            if (o0 !== core_out || oe0 !== core_oeb || id0 !== core_inp_dis || dm0 !== core_dm) begin
                miscompares++;
                $display("[TB] FAIL passthrough: got out %h oeb %h dis %h want %h %h %h",
                         o0, oe0, id0, core_out, core_oeb, core_inp_dis);
            end
            vectors++;
            if (busy0 !== 1'b0 || done0 !== want_done) begin
                miscompares++;
                $display("[TB] FAIL passthrough_flags: got busy %b done %b want 0 %b", busy0, done0, want_done);
            end
        end
    endtask

    task automatic test_runs();
        exp_t e;
        for (int sc = 0; sc < 2; sc++) begin
            stuck5 = (sc == 1); short1213 = (sc == 1); open67 = (sc == 1);
            e = '{dut: 0, lat: 25,  mask: (sc == 1) ? 38'h20   : 38'h0, pass: (sc == 0)};
            sb.push_back(e);
            e = '{dut: 1, lat: 253, mask: (sc == 1) ? 38'h3000 : 38'h0, pass: (sc == 0)};
            sb.push_back(e);
            e = '{dut: 2, lat: 75,  mask: (sc == 1) ? 38'hC0   : 38'h0, pass: (sc == 0)};
            sb.push_back(e);
            run_and_wait(-1);
            vectors++;
            if (s_busy !== 1'b1 || s_out !== '0 || s_oeb !== '0 || s_dm !== {NP{3'b110}}) begin
                miscompares++;
                $display("[TB] FAIL setup_pads: got busy %b out %h oeb %h dm %h", s_busy, s_out, s_oeb, s_dm);
            end
            while (sb.size() > 0) begin
                e = sb.pop_front();
                vectors++;
                if (!got_seen[e.dut]) begin
                    miscompares++;
                    $display("[TB] FAIL dut%0d timeout: got no done within %0d cycles want done", e.dut, LIMIT);
                end
                vectors++;
                if (got_lat[e.dut] !== e.lat) begin
                    miscompares++;
                    $display("[TB] FAIL dut%0d latency: got %0d want %0d", e.dut, got_lat[e.dut], e.lat);
                end
                vectors++;
                if (got_mask[e.dut] !== e.mask || got_pass[e.dut] !== e.pass) begin
                    miscompares++;
                    $display("[TB] FAIL dut%0d result: got mask %h pass %b want %h %b",
                             e.dut, got_mask[e.dut], got_pass[e.dut], e.mask, e.pass);
                end
                vectors++;
                if (got_busy[e.dut] !== 1'b0) begin
                    miscompares++;
                    $display("[TB] FAIL dut%0d busy_at_done: got %b want 0", e.dut, got_busy[e.dut]);
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        exp_t e;
        stuck5 = 1'b0; short1213 = 1'b0; open67 = 1'b0;
        e = '{dut: 0, lat: 25, mask: 38'h0, pass: 1'b1};
        sb.push_back(e);
        run_and_wait(5);
        vectors++;
        if (s_done !== 1'b0 || s_mask !== '0) begin
            miscompares++;
            $display("[TB] FAIL restart_clear: got done %b mask %h want 0 0", s_done, s_mask);
        end
        while (sb.size() > 0) begin
            e = sb.pop_front();
            vectors++;
            if (!got_seen[e.dut] || got_lat[e.dut] !== e.lat) begin
                miscompares++;
                $display("[TB] FAIL busy_start_latency: got %0d (seen %b) want %0d",
                         got_lat[e.dut], got_seen[e.dut], e.lat);
            end
            vectors++;
            if (got_pass[e.dut] !== e.pass || got_mask[e.dut] !== e.mask) begin
                miscompares++;
                $display("[TB] FAIL busy_start_result: got pass %b mask %h want %b %h",
                         got_pass[e.dut], got_mask[e.dut], e.pass, e.mask);
            end
        end
    endtask

    task automatic test_abort();
        stuck5 = 1'b1;
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        repeat (9) @(negedge clk);
        abort = 1'b1;
        @(negedge clk); abort = 1'b0;
        vectors++;
        if (busy_v !== 3'b000 || done_v !== 3'b000) begin
            miscompares++;
            $display("[TB] FAIL abort_flags: got busy %b done %b want 000 000", busy_v, done_v);
        end
        vectors++;
        if (o0 !== core_out || oe0 !== core_oeb || dm0 !== core_dm) begin
            miscompares++;
            $display("[TB] FAIL abort_pads: got out %h oeb %h want %h %h", o0, oe0, core_out, core_oeb);
        end
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        repeat (15) @(negedge clk);
        vectors++;
        if (mask0 !== 38'h20) begin
            miscompares++;
            $display("[TB] FAIL midrun_mask: got %h want %h", mask0, 38'h20);
        end
        repeat (4) @(negedge clk);
        abort = 1'b1;
        @(negedge clk); abort = 1'b0;
        vectors++;
        if (busy0 !== 1'b0 || done0 !== 1'b0 || mask0 !== 38'h20) begin
            miscompares++;
            $display("[TB] FAIL abort_retain: got busy %b done %b mask %h want 0 0 %h", busy0, done0, mask0, 38'h20);
        end
        @(negedge clk); start = 1'b1; abort = 1'b1;
        @(negedge clk); start = 1'b0; abort = 1'b0;
        vectors++;
        if (busy0 !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL start_beats_abort: got busy %b want 1", busy0);
        end
        abort = 1'b1;
        @(negedge clk); abort = 1'b0;
    endtask

    task automatic test_reset_mid();
        stuck5 = 1'b1;
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        repeat (15) @(negedge clk);
        RSTB = 1'b1;
        @(negedge clk);
        vectors++;
        if ({busy_v, done_v, pass_v} !== 9'b0 || mask0 !== '0) begin
            miscompares++;
            $display("[TB] FAIL reset_mid: got flags %b mask %h want 0 0", {busy_v, done_v, pass_v}, mask0);
        end
        vectors++;
        if (o0 !== core_out || oe0 !== core_oeb || id0 !== core_inp_dis) begin
            miscompares++;
            $display("[TB] FAIL reset_mid_pads: got out %h oeb %h want %h %h", o0, oe0, core_out, core_oeb);
        end
        RSTB = 1'b0;
        stuck5 = 1'b0;
    endtask

    initial begin
        test_reset();
        test_passthrough(1'b0);
        test_runs();
        test_passthrough(1'b1);
        test_back_to_back();
        test_abort();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
